// File: rtl/glyph_blitter.sv
// glyph_blitter: expands one 8x32 one-bit glyph from a registered-read glyph ROM
// into framebuffer pixel writes. Walks 256 pixels row-major and clips writes at the
// right and bottom framebuffer edges. Bit-0 pixels can be skipped (transparent mode).
module glyph_blitter #(
    parameter int unsigned H_RES   = 320,
    parameter int unsigned V_RES   = 240,
    parameter int unsigned XW      = 9,
    parameter int unsigned YW      = 8,
    parameter int unsigned FB_AW   = 17,
    parameter int unsigned COLOR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         char_idx,
    input  logic [XW-1:0]      x0,
    input  logic [YW-1:0]      y0,
    input  logic [COLOR_W-1:0] fg,
    input  logic [COLOR_W-1:0] bg,
    input  logic               transparent,
    output logic               busy,
    output logic               done,
    output logic [11:0]        rom_address,
    input  logic               rom_q,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [COLOR_W-1:0] fb_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]         state;
    logic [7:0]         cnt;
    logic               drain_cnt;
    logic [3:0]         char_l;
    logic [XW-1:0]      x0_l;
    logic [YW-1:0]      y0_l;
    logic [COLOR_W-1:0] fg_l;
    logic [COLOR_W-1:0] bg_l;
    logic               transparent_l;
    logic [11:0]        rom_address_q;

    // Pixel index delayed one cycle so it lines up with rom_q.
    logic               pix_v;
    logic [7:0]         pix_cnt;

    logic               fb_we_q;
    logic [FB_AW-1:0]   fb_addr_q;
    logic [COLOR_W-1:0] fb_data_q;
    logic               done_q;

    logic [4:0]         row;
    logic [2:0]         col;
    logic [XW:0]        px;
    logic [YW:0]        py;
    logic [31:0]        addr_full;
    logic               clipped;
    logic               skip_bg;

    // Request acceptance, ROM address sequencing and pipeline drain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            drain_cnt     <= 1'b0;
            char_l        <= 4'd0;
            x0_l          <= '0;
            y0_l          <= '0;
            fg_l          <= '0;
            bg_l          <= '0;
            transparent_l <= 1'b0;
            rom_address_q <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        char_l        <= char_idx;
                        x0_l          <= x0;
                        y0_l          <= y0;
                        fg_l          <= fg;
                        bg_l          <= bg;
                        transparent_l <= transparent;
                        cnt           <= 8'd0;
                        rom_address_q <= {char_idx, 8'd0};
                        state         <= READ;
                    end
                end
                READ: begin
                    if (cnt == 8'd255) begin
                        // Address holds on the last pixel while the pipeline empties.
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        cnt           <= cnt + 8'd1;
                        rom_address_q <= {char_l, cnt + 8'd1};
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay the pixel index by the ROM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_v   <= 1'b0;
            pix_cnt <= 8'd0;
        end else begin
            pix_v   <= (state == READ);
            pix_cnt <= cnt;
        end
    end

    // Screen position, clip test and linear address of the pixel whose bit is on rom_q.
    always_comb begin
        row       = pix_cnt[7:3];
        col       = pix_cnt[2:0];
        px        = (XW+1)'(x0_l) + (XW+1)'(col);
        py        = (YW+1)'(y0_l) + (YW+1)'(row);
        addr_full = 32'(py) * H_RES + 32'(px);
        clipped   = (32'(px) >= H_RES) || (32'(py) >= V_RES);
        skip_bg   = transparent_l && !rom_q;
    end

    // Framebuffer write port and completion pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            fb_we_q <= pix_v && !clipped && !skip_bg;
            done_q  <= pix_v && (pix_cnt == 8'd255);
            if (pix_v) begin
                fb_addr_q <= addr_full[FB_AW-1:0];
                fb_data_q <= rom_q ? fg_l : bg_l;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign rom_address = rom_address_q;
    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_data     = fb_data_q;

endmodule

// File: tb/tb_glyph_blitter.sv
// Bench for glyph_blitter: directed and random draws, checked cycle by cycle against
// a pixel-level model of the draw (position, clip, transparency, timing).
module tb_glyph_blitter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  char_idx;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [15:0] fg;
    logic [15:0] bg;
    logic        transparent;
    logic        busy;
    logic        done;
    logic [11:0] rom_address;
    logic        rom_q;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;

    int n_total;
    int n_pass;

    logic [15:0] fbm [0:76799];

    glyph_blitter dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .char_idx    (char_idx),
        .x0          (x0),
        .y0          (y0),
        .fg          (fg),
        .bg          (bg),
        .transparent (transparent),
        .busy        (busy),
        .done        (done),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Glyph ROM: registered read, bit = addr[0] ^ addr[3].
    always @(posedge clock) rom_q <= rom_address[0] ^ rom_address[3];

    // Framebuffer image built from observed writes.
    always @(posedge clock) begin
        if (fb_we === 1'b1 && fb_addr < 17'd76800) fbm[fb_addr] <= fb_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit glyph_bit(input int k);
        return ((k % 2) != 0) ^ (((k / 8) % 2) != 0);
    endfunction

    // One draw, accepted on the next rising edge; checks every cycle 1..259.
    // Returns at the falling edge of cycle 259 (or of abort_at, with reset raised).
    task automatic draw(input logic [3:0] c, input int x, input int y,
                        input logic [15:0] f, input logic [15:0] b, input logic tr,
                        input bit rej, input int abort_at,
                        output int nw, output int first_addr, output int first_data,
                        output int last_addr);
        int k, row, col, px, py, ew;
        logic exp_we;
        int exp_addr;
        logic [15:0] exp_data;
        logic [7:0] ek;
        nw = 0; ew = 0; first_addr = -1; first_data = -1; last_addr = -1;
        char_idx = c; x0 = 9'(x); y0 = 8'(y); fg = f; bg = b; transparent = tr;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int n = 1; n <= 259; n++) begin
            @(negedge clock);
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_fb_we", 32'(fb_we), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_rom_address", 32'(rom_address), 32'd0);
                return;
            end
            exp_we = 1'b0; exp_addr = 0; exp_data = 16'd0;
            if (n >= 3 && n <= 258) begin
                k = n - 3; row = k / 8; col = k % 8;
                px = x + col; py = y + row;
                exp_data = glyph_bit(k) ? f : b;
                exp_addr = py * 320 + px;
                exp_we = (px < 320) && (py < 240) && (!tr || glyph_bit(k));
            end
            chk("busy", 32'(busy), 32'(n <= 258));
            chk("done", 32'(done), 32'(n == 258));
            chk("fb_we", 32'(fb_we), 32'(exp_we));
            if (exp_we) begin
                chk("fb_addr", 32'(fb_addr), 32'(exp_addr));
                chk("fb_data", 32'(fb_data), 32'(exp_data));
                ew++;
            end
            if (fb_we === 1'b1) begin
                if (nw == 0) begin
                    first_addr = 32'(fb_addr);
                    first_data = 32'(fb_data);
                end
                last_addr = 32'(fb_addr);
                nw++;
            end
            if (n <= 258) begin
                ek = (n <= 256) ? 8'(n - 1) : 8'd255;
                chk("rom_address", 32'(rom_address), 32'({c, ek}));
            end
            // Operand inputs are don't-care once the request is latched.
            char_idx = 4'($urandom); x0 = 9'($urandom); y0 = 8'($urandom);
            fg = 16'($urandom); bg = 16'($urandom); transparent = 1'($urandom);
            start = rej && (n == 1 || n == 100 || n == 258);
        end
        start = 1'b0;
        chk("write_count_model", 32'(nw), 32'(ew));
    endtask

    int nw, fa, fd, la, cnt_w;
    int rc, rx, ry, row, col;
    logic [15:0] rf, rb;
    logic rt;

    initial begin
        n_total = 0; n_pass = 0;
        reset = 1'b1; start = 1'b0; char_idx = 4'd0; x0 = 9'd0; y0 = 8'd0;
        fg = 16'd0; bg = 16'd0; transparent = 1'b0;
        #2;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_fb_we", 32'(fb_we), 32'd0);
        chk("init_rom_address", 32'(rom_address), 32'd0);
        chk("init_fb_addr", 32'(fb_addr), 32'd0);
        chk("init_fb_data", 32'(fb_data), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Basic draw.
        draw(4'd2, 10, 20, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, nw, fa, fd, la);
        chk("basic_writes", 32'(nw), 32'd256);
        chk("basic_first_addr", 32'(fa), 32'd6410);
        chk("basic_first_data", 32'(fd), 32'h0000);

        // Transparency.
        draw(4'd2, 10, 20, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, nw, fa, fd, la);
        chk("transp_writes", 32'(nw), 32'd128);
        chk("transp_first_data", 32'(fd), 32'hFFFF);

        // Clipping at the bottom-right corner.
        draw(4'd7, 316, 230, 16'h1111, 16'h2222, 1'b0, 1'b0, 0, nw, fa, fd, la);
        chk("clip_writes", 32'(nw), 32'd40);
        chk("clip_last_addr", 32'(la), 32'd76799);

        // Busy rejection, then a request accepted at E259.
        draw(4'd5, 40, 50, 16'hABCD, 16'h1357, 1'b0, 1'b1, 0, nw, fa, fd, la);
        chk("reject_writes", 32'(nw), 32'd256);
        draw(4'd9, 100, 100, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 0, nw, fa, fd, la);
        chk("after_reject_writes", 32'(nw), 32'd256);

        // Reset mid-draw.
        draw(4'd3, 0, 0, 16'h7777, 16'h8888, 1'b0, 1'b0, 120, nw, fa, fd, la);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cnt_w = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (fb_we !== 1'b0 || busy !== 1'b0) cnt_w++;
        end
        chk("post_reset_activity", 32'(cnt_w), 32'd0);
        draw(4'd3, 0, 0, 16'h7777, 16'h8888, 1'b0, 1'b0, 0, nw, fa, fd, la);
        chk("fresh_writes", 32'(nw), 32'd256);

        // Back-to-back: glyph 15 overwrites glyph 0 at the origin.
        draw(4'd0, 0, 0, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 0, nw, fa, fd, la);
        draw(4'd15, 0, 0, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, nw, fa, fd, la);
        for (int k = 0; k < 256; k++) begin
            row = k / 8; col = k % 8;
            chk("fb_overwrite", 32'(fbm[row * 320 + col]),
                32'(glyph_bit(k) ? 16'h1234 : 16'h4321));
        end

        // Random draws, some partly or fully clipped.
        for (int i = 0; i < 8; i++) begin
            rc = int'($urandom_range(0, 15));
            rx = int'($urandom_range(0, 330));
            ry = int'($urandom_range(0, 245));
            rf = 16'($urandom); rb = 16'($urandom); rt = 1'($urandom);
            draw(4'(rc), rx, ry, rf, rb, rt, 1'b0, 0, nw, fa, fd, la);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
